sync_up_counter_mod: RTL

Synchronous N-bit modulo up-counter with prescaler, parallel load, terminal-count, wrap and sticky-overflow flags. It is the up-counting counterpart to the ripple down-counter in the counters library. All flip-flops share one clock, so every output bit changes on the same edge with no ripple skew. It sits wherever a deterministic up-count is needed: timers, baud dividers, event tallies.

---
 rtl/sync_up_counter_mod_if.sv | 40 ++++
 rtl/sync_up_counter_mod.sv | 106 ++++++++++
 2 files changed

// File: rtl/sync_up_counter_mod_if.sv
// sync_up_counter_mod_if
//   Control and status bundle for sync_up_counter_mod.
//   Parameter:
//     N         counter width in bits
//   Signals:
//     en        count enable
//     clr       synchronous clear of counter and prescaler
//     load      synchronous parallel load
//     load_val  value to load (clamped to MODULUS-1 by the counter)
//     ovf_clr   clears the sticky overflow flag
//     Q         current count
//     tc        terminal count (Q == MODULUS-1), combinational
//     wrap      one-cycle pulse on rollover
//     ovf       sticky overflow flag
//   Modports:
//     master    drives controls, observes status
//     slave     the counter side
interface sync_up_counter_mod_if #(
    parameter int unsigned N = 7
);
    logic         en;
    logic         clr;
    logic         load;
    logic [N-1:0] load_val;
    logic         ovf_clr;
    logic [N-1:0] Q;
    logic         tc;
    logic         wrap;
    logic         ovf;

    modport master (
        output en, clr, load, load_val, ovf_clr,
        input  Q, tc, wrap, ovf
    );

    modport slave (
        input  en, clr, load, load_val, ovf_clr,
        output Q, tc, wrap, ovf
    );
endinterface

// File: rtl/sync_up_counter_mod.sv
// sync_up_counter_mod
//   Synchronous N-bit modulo up-counter with prescaler, parallel load,
//   terminal-count, wrap pulse and sticky overflow flag. All state is on a
//   single clock, so every count bit changes on the same edge.
//   Parameters:
//     N        counter width in bits (N >= 1)
//     MODULUS  count range 0..MODULUS-1 (2 <= MODULUS <= 2**N)
//     DIV      enabled cycles per count step (DIV >= 1)
//   Ports:
//     clk      rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      slave side of sync_up_counter_mod_if (controls in, status out)
//   Configuration macro:
//     SYNC_UP_COUNTER_SAT_EN  when defined, a step at MODULUS-1 holds the
//                             count there (saturating); wrap never asserts.
//                             Default: wrap-around to 0.
module sync_up_counter_mod #(
    parameter int unsigned N       = 7,
    parameter int unsigned MODULUS = 2 ** N,
    parameter int unsigned DIV     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sync_up_counter_mod_if.slave  bus
);

`ifdef SYNC_UP_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [N-1:0] TOP = N'(MODULUS - 1);

    logic [N-1:0] q;
    logic         wrap_r;
    logic         ovf_r;
    logic         step;
    logic         at_top;
    logic         hold;       // clr or load overrides counting this cycle
    logic [N-1:0] load_clamped;

    assign at_top       = (q == TOP);
    assign hold         = bus.clr || bus.load;
    assign load_clamped = (bus.load_val > TOP) ? TOP : bus.load_val;

    // Prescaler: advances only on enabled cycles not overridden by clr/load,
    // and step fires on its last phase. With DIV=1 there is no prescaler.
    generate
        if (DIV > 1) begin : g_pre
            localparam int unsigned PW = $clog2(DIV);
            localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
            logic [PW-1:0] pre;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pre <= '0;
                end else if (hold) begin
                    pre <= '0;
                end else if (bus.en) begin
                    pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
                end
            end

            assign step = bus.en && (pre == PRE_LAST);
        end else begin : g_nopre
            assign step = bus.en;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q      <= '0;
            wrap_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            wrap_r <= 1'b0;

            // Set beats clear when both happen in the same cycle.
            if (!hold && step && at_top) begin
                ovf_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_r <= 1'b0;
            end

            if (bus.clr) begin
                q <= '0;
            end else if (bus.load) begin
                q <= load_clamped;
            end else if (step) begin
                if (at_top) begin
                    q      <= SAT ? q : '0;
                    wrap_r <= !SAT;
                end else begin
                    q <= q + N'(1);
                end
            end
        end
    end

    assign bus.Q    = q;
    assign bus.tc   = at_top;
    assign bus.wrap = wrap_r;
    assign bus.ovf  = ovf_r;

endmodule
